// File: rtl/p_3_sched.sv
// Round-robin scheduler feeding a shared registered logic pipeline (D=A&B&C, G=~A&~B, E=D|G|F).
// Define P3_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module p_3_sched #(
  parameter int N_REQ  = 4,
  parameter int DP_LAT = 2,
  parameter int IDW    = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [4*N_REQ-1:0]   i_req_data,
  output logic [N_REQ-1:0]     o_gnt,
  output logic                 o_dp_a,
  output logic                 o_dp_b,
  output logic                 o_dp_c,
  output logic                 o_dp_f,
  input  logic                 i_dp_e,
  output logic                 o_rsp_valid,
  output logic [IDW-1:0]       o_rsp_id,
  output logic                 o_rsp_e,
  output logic                 o_busy
);

  // state | meaning
  // IDLE  | nothing requested, nothing in flight
  // RUN   | launching operand sets
  // DRAIN | no eligible requester, waiting on in-flight tags
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [N_REQ-1:0]     r_pend;
  logic [N_REQ-1:0]     w_elig;
  logic [N_REQ-1:0]     w_onehot;
  logic [N_REQ-1:0]     w_clr;
  logic                 w_found;
  logic [IDW-1:0]       w_sel;
  logic [3:0]           w_data;
  logic [DP_LAT-1:0]    r_f_sr;
  logic [DP_LAT:0]      r_tag_vld;
  logic [IDW-1:0]       r_tag_id [DP_LAT+1];
  logic                 w_in_flight;
  logic                 w_any_req;

  assign w_elig = i_req & ~r_pend;

`ifdef P3_SCHED_FIXED_PRIO_EN
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_found = 1'b1;
        w_sel   = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0]       r_ptr;
  logic [2*N_REQ-1:0]   w_dbl;
  logic [N_REQ-1:0]     w_rot;

  // Rotate eligibility so bit 0 is the requester at the pointer.
  assign w_dbl = {w_elig, w_elig};
  assign w_rot = N_REQ'(w_dbl >> r_ptr);

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (w_rot[off]) begin
        w_found = 1'b1;
        w_sel   = IDW'((int'(r_ptr) + off) % N_REQ);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= IDW'((int'(w_sel) + 1) % N_REQ);
    end
  end
`endif

  always_comb begin
    w_onehot = '0;
    w_data   = '0;
    w_clr    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_found && (w_sel == IDW'(i))) begin
        w_onehot[i] = 1'b1;
        w_data      = i_req_data[4*i +: 4];
      end
      if (r_tag_vld[DP_LAT] && (r_tag_id[DP_LAT] == IDW'(i))) begin
        w_clr[i] = 1'b1;
      end
    end
  end

  assign w_in_flight = |r_tag_vld;
  assign w_any_req   = |i_req;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!w_in_flight && !w_any_req)   w_state_nxt = S_IDLE;
        else if (!w_found && w_in_flight) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!w_in_flight && !w_any_req) w_state_nxt = S_IDLE;
        else if (w_found)               w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_dp_f = r_f_sr[DP_LAT-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_gnt       <= '0;
      o_dp_a      <= 1'b0;
      o_dp_b      <= 1'b0;
      o_dp_c      <= 1'b0;
      r_f_sr      <= '0;
      r_pend      <= '0;
      r_tag_vld   <= '0;
      for (int s = 0; s <= DP_LAT; s++) r_tag_id[s] <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_e     <= 1'b0;
    end else begin
      o_gnt     <= w_onehot;
      o_dp_a    <= w_data[3];
      o_dp_b    <= w_data[2];
      o_dp_c    <= w_data[1];
      // F trails A/B/C by DP_LAT-1 edges so E combines operands of one launch.
      r_f_sr    <= {r_f_sr[DP_LAT-2:0], w_data[0]};
      r_pend    <= (r_pend & ~w_clr) | w_onehot;
      r_tag_vld <= {r_tag_vld[DP_LAT-1:0], w_found};
      r_tag_id[0] <= w_sel;
      for (int s = 1; s <= DP_LAT; s++) r_tag_id[s] <= r_tag_id[s-1];
      o_rsp_valid <= r_tag_vld[DP_LAT];
      o_rsp_id    <= r_tag_vld[DP_LAT] ? r_tag_id[DP_LAT] : '0;
      o_rsp_e     <= r_tag_vld[DP_LAT] & i_dp_e;
    end
  end

endmodule
